// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: 3-entry destination scoreboard (EX/MEM/WB), operand
// forwarding selects, load-use stall detection and branch flush control.
module hazard_forward_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  ID_RS,
   input  logic [4:0]  ID_RT,
   input  logic        ID_USES_RS,
   input  logic        ID_USES_RT,
   input  logic        ID_RF_ENABLE,
   input  logic        ID_LOAD_INSTR,
   input  logic [4:0]  ID_DEST,
   input  logic        ID_BRANCH_TAKEN,
   output logic        PC_LE,
   output logic        IFID_LE,
   output logic        IFID_FLUSH,
   output logic        IDEX_NOP,
   output logic [1:0]  FWD_A,
   output logic [1:0]  FWD_B,
   output logic        OUT_EnableEX,
   output logic        OUT_EnableMEM,
   output logic        OUT_EnableWB,
   output logic [4:0]  OUT_regEX,
   output logic [4:0]  OUT_regMEM,
   output logic [4:0]  OUT_regWB,
   output logic [15:0] STALL_CNT
);

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} ctl_state_t;

   localparam logic [1:0] SRC_RF  = 2'b00;
   localparam logic [1:0] SRC_EX  = 2'b01;
   localparam logic [1:0] SRC_MEM = 2'b10;
   localparam logic [1:0] SRC_WB  = 2'b11;

   // Scoreboard: p0 = EX, p1 = MEM, p2 = WB
   logic       vld_p0, vld_p1, vld_p2;
   logic       ld_p0,  ld_p1,  ld_p2;
   logic [4:0] dst_p0, dst_p1, dst_p2;

   ctl_state_t state_q;
   logic [15:0] stall_cnt_q;
   logic        lu;

   // A load in EX has no result yet, so it can only ever be picked up from MEM onward.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       uses,
      input logic       v0, input logic l0, input logic [4:0] d0,
      input logic       v1, input logic [4:0] d1,
      input logic       v2, input logic [4:0] d2
   );
      logic [1:0] sel;
      sel = SRC_RF;
      if (uses && (src != 5'd0)) begin
         if (v0 && !l0 && (d0 == src))
            sel = SRC_EX;
         else if (v1 && (d1 == src))
            sel = SRC_MEM;
         else if (v2 && (d2 == src))
            sel = SRC_WB;
      end
      return sel;
   endfunction

   function automatic logic load_use(
      input logic [4:0] rs, input logic use_rs,
      input logic [4:0] rt, input logic use_rt,
      input logic v0, input logic l0, input logic [4:0] d0
   );
      return v0 && l0 && ((use_rs && (rs == d0)) || (use_rt && (rt == d0)));
   endfunction

   always_comb begin
      lu         = load_use(ID_RS, ID_USES_RS, ID_RT, ID_USES_RT, vld_p0, ld_p0, dst_p0);
      PC_LE      = 1'b1;
      IFID_LE    = 1'b1;
      IFID_FLUSH = 1'b0;
      IDEX_NOP   = 1'b0;
      FWD_A      = SRC_RF;
      FWD_B      = SRC_RF;
      if (lu) begin
         // Stall wins over a taken branch; the branch is re-evaluated once the load clears.
         PC_LE    = 1'b0;
         IFID_LE  = 1'b0;
         IDEX_NOP = 1'b1;
      end else begin
         IFID_FLUSH = ID_BRANCH_TAKEN;
         FWD_A = fwd_sel(ID_RS, ID_USES_RS, vld_p0, ld_p0, dst_p0,
                         vld_p1, dst_p1, vld_p2, dst_p2);
         FWD_B = fwd_sel(ID_RT, ID_USES_RT, vld_p0, ld_p0, dst_p0,
                         vld_p1, dst_p1, vld_p2, dst_p2);
      end
   end

   // ---- scoreboard shift: ID -> EX -> MEM -> WB ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vld_p0 <= 1'b0; ld_p0 <= 1'b0; dst_p0 <= 5'd0;
         vld_p1 <= 1'b0; ld_p1 <= 1'b0; dst_p1 <= 5'd0;
         vld_p2 <= 1'b0; ld_p2 <= 1'b0; dst_p2 <= 5'd0;
      end else begin
         vld_p2 <= vld_p1; ld_p2 <= ld_p1; dst_p2 <= dst_p1;
         vld_p1 <= vld_p0; ld_p1 <= ld_p0; dst_p1 <= dst_p0;
         if (IDEX_NOP) begin
            vld_p0 <= 1'b0;
            ld_p0  <= 1'b0;
            dst_p0 <= 5'd0;
         end else begin
            vld_p0 <= ID_RF_ENABLE && (ID_DEST != 5'd0);
            ld_p0  <= ID_LOAD_INSTR;
            dst_p0 <= ID_DEST;
         end
      end
   end

   // ---- control state and stall statistics ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= 16'd0;
      end else begin
         if (lu)
            state_q <= ST_STALL;
         else if (ID_BRANCH_TAKEN)
            state_q <= ST_FLUSH;
         else
            state_q <= ST_RUN;
         if (lu && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
         // The bubble inserted by a stall empties EX, so a second stall cannot follow.
         assert (!((state_q == ST_STALL) && lu));
      end
   end

   assign OUT_EnableEX  = vld_p0;
   assign OUT_EnableMEM = vld_p1;
   assign OUT_EnableWB  = vld_p2;
   assign OUT_regEX     = dst_p0;
   assign OUT_regMEM    = dst_p1;
   assign OUT_regWB     = dst_p2;
   assign STALL_CNT     = stall_cnt_q;

   logic unused_ok;
   assign unused_ok = ^{ld_p1, ld_p2};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding chain, load-use stall,
// $0 handling, forward priority, stall-vs-branch and reset during a stall.
module tb_hazard_forward_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  ID_RS, ID_RT, ID_DEST;
   logic        ID_USES_RS, ID_USES_RT, ID_RF_ENABLE, ID_LOAD_INSTR, ID_BRANCH_TAKEN;
   logic        PC_LE, IFID_LE, IFID_FLUSH, IDEX_NOP;
   logic [1:0]  FWD_A, FWD_B;
   logic        OUT_EnableEX, OUT_EnableMEM, OUT_EnableWB;
   logic [4:0]  OUT_regEX, OUT_regMEM, OUT_regWB;
   logic [15:0] STALL_CNT;

   int checks = 0;
   int errors = 0;

   hazard_forward_unit dut (
      .Clk(Clk), .Reset(Reset),
      .ID_RS(ID_RS), .ID_RT(ID_RT),
      .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
      .ID_RF_ENABLE(ID_RF_ENABLE), .ID_LOAD_INSTR(ID_LOAD_INSTR),
      .ID_DEST(ID_DEST), .ID_BRANCH_TAKEN(ID_BRANCH_TAKEN),
      .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_FLUSH(IFID_FLUSH), .IDEX_NOP(IDEX_NOP),
      .FWD_A(FWD_A), .FWD_B(FWD_B),
      .OUT_EnableEX(OUT_EnableEX), .OUT_EnableMEM(OUT_EnableMEM), .OUT_EnableWB(OUT_EnableWB),
      .OUT_regEX(OUT_regEX), .OUT_regMEM(OUT_regMEM), .OUT_regWB(OUT_regWB),
      .STALL_CNT(STALL_CNT)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic rfe, input logic ld,
                         input logic [4:0] dst, input logic br);
      ID_RS = rs; ID_USES_RS = urs;
      ID_RT = rt; ID_USES_RT = urt;
      ID_RF_ENABLE = rfe; ID_LOAD_INSTR = ld;
      ID_DEST = dst; ID_BRANCH_TAKEN = br;
      #1;
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick; tick;
      Reset = 1'b0;
      #1;
      chk("rst_en_ex",  {15'd0, OUT_EnableEX}, 16'd0);
      chk("rst_reg_ex", {11'd0, OUT_regEX},    16'd0);
      chk("rst_cnt",    STALL_CNT,             16'd0);
      chk("rst_pc_le",  {15'd0, PC_LE},        16'd1);

      // ALU-ALU chain: add $3 then a reader of rs=3 through EX, MEM, WB
      set_id(1, 1, 2, 1, 1, 0, 3, 0);
      tick;
      set_id(3, 1, 3, 0, 0, 0, 0, 0);
      chk("alu_en_ex",  {15'd0, OUT_EnableEX}, 16'd1);
      chk("alu_reg_ex", {11'd0, OUT_regEX},    16'd3);
      chk("alu_fwd_ex", {14'd0, FWD_A},        16'd1);
      chk("alu_b_unused", {14'd0, FWD_B},      16'd0);
      tick;
      chk("alu_fwd_mem", {14'd0, FWD_A}, 16'd2);
      tick;
      chk("alu_fwd_wb",  {14'd0, FWD_A}, 16'd3);
      set_id(0, 0, 3, 1, 0, 0, 0, 0);
      chk("alu_fwdb_wb", {14'd0, FWD_B}, 16'd3);
      tick;
      set_id(3, 1, 0, 0, 0, 0, 0, 0);
      chk("alu_fwd_rf",  {14'd0, FWD_A}, 16'd0);

      // Load-use: lw $5, then add $6 reading rt=5
      set_id(1, 1, 0, 0, 1, 1, 5, 0);
      tick;
      set_id(0, 0, 5, 1, 1, 0, 6, 0);
      chk("lu_pc_le",   {15'd0, PC_LE},    16'd0);
      chk("lu_ifid_le", {15'd0, IFID_LE},  16'd0);
      chk("lu_nop",     {15'd0, IDEX_NOP}, 16'd1);
      chk("lu_fwdb",    {14'd0, FWD_B},    16'd0);
      chk("lu_cnt0",    STALL_CNT,         16'd0);
      tick;
      chk("lu_cnt1",    STALL_CNT,         16'd1);
      chk("lu_fwdb_mem", {14'd0, FWD_B},   16'd2);
      chk("lu_pc_le2",  {15'd0, PC_LE},    16'd1);
      chk("lu_bubble",  {15'd0, OUT_EnableEX}, 16'd0);
      chk("lu_reg_mem", {11'd0, OUT_regMEM}, 16'd5);
      tick;
      chk("lu_add_ex",  {11'd0, OUT_regEX}, 16'd6);

      // $0 target never becomes a forwarding source
      set_id(1, 1, 0, 0, 1, 0, 0, 0);
      tick;
      set_id(0, 1, 0, 1, 0, 0, 0, 0);
      chk("z_en_ex", {15'd0, OUT_EnableEX}, 16'd0);
      chk("z_fwd_a", {14'd0, FWD_A},        16'd0);

      // Priority: $7 in both EX and MEM, EX wins
      set_id(1, 1, 0, 0, 1, 0, 7, 0);
      tick;
      set_id(2, 1, 0, 0, 1, 0, 7, 0);
      tick;
      set_id(7, 1, 0, 0, 0, 0, 0, 0);
      chk("pri_reg_mem", {11'd0, OUT_regMEM}, 16'd7);
      chk("pri_fwd_a",   {14'd0, FWD_A},      16'd1);
      tick;
      chk("pri_fwd_mem", {14'd0, FWD_A},      16'd2);

      // Stall vs branch: lw $9, then a taken branch reading rs=9
      set_id(1, 1, 0, 0, 1, 1, 9, 0);
      tick;
      set_id(9, 1, 0, 0, 0, 0, 0, 1);
      chk("sb_flush0", {15'd0, IFID_FLUSH}, 16'd0);
      chk("sb_nop",    {15'd0, IDEX_NOP},   16'd1);
      chk("sb_pc_le",  {15'd0, PC_LE},      16'd0);
      tick;
      chk("sb_flush1", {15'd0, IFID_FLUSH}, 16'd1);
      chk("sb_nop0",   {15'd0, IDEX_NOP},   16'd0);
      chk("sb_fwd_a",  {14'd0, FWD_A},      16'd2);
      chk("sb_cnt",    STALL_CNT,           16'd2);

      // Reset during a stall: lw $4, reader of rs=4, Reset while stalled
      set_id(1, 1, 0, 0, 1, 1, 4, 0);
      tick;
      set_id(4, 1, 0, 0, 0, 0, 0, 0);
      chk("rs_lu_pc", {15'd0, PC_LE}, 16'd0);
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      #1;
      chk("rs_reg_ex",  {11'd0, OUT_regEX},  16'd0);
      chk("rs_reg_mem", {11'd0, OUT_regMEM}, 16'd0);
      chk("rs_reg_wb",  {11'd0, OUT_regWB},  16'd0);
      chk("rs_cnt",     STALL_CNT,           16'd0);
      chk("rs_pc_le",   {15'd0, PC_LE},      16'd1);
      chk("rs_fwd_a",   {14'd0, FWD_A},      16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL use reset Reset, synchronous, active-high, and clock Clk.
REQ-002 The block SHALL have these ports, one per line as name  direction  width  meaning:
- Clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous active-high reset
- ID_RS  in  5  rs field of the instruction in ID
- ID_RT  in  5  rt field of the instruction in ID
- ID_USES_RS  in  1  ID instruction reads rs
- ID_USES_RT  in  1  ID instruction reads rt
- ID_RF_ENABLE  in  1  ID instruction writes the register file
- ID_LOAD_INSTR  in  1  ID instruction is a load
- ID_DEST  in  5  destination register of the ID instruction
- ID_BRANCH_TAKEN  in  1  taken branch/jump resolved in ID
- PC_LE  out  1  PC load enable
- IFID_LE  out  1  IF/ID register load enable
- IFID_FLUSH  out  1  IF/ID register clears to NOP on the next edge
- IDEX_NOP  out  1  ID/EX register captures all-zero control signals
- FWD_A  out  2  rs operand source select
- FWD_B  out  2  rt operand source select
- OUT_EnableEX, OUT_EnableMEM, OUT_EnableWB  out  1 each  scoreboard write-valid per stage
- OUT_regEX, OUT_regMEM, OUT_regWB  out  5 each  scoreboard destination per stage
- STALL_CNT  out  16  number of load-use stall cycles since reset
REQ-003 FWD encoding SHALL be: 00 register file, 01 EX result, 10 MEM result, 11 WB result.

Function
REQ-004 The block SHALL keep a 3-entry shift scoreboard (EX, MEM, WB). Each entry SHALL hold {valid, load, dest[4:0]}.
REQ-005 On each posedge without Reset:
- WB <= MEM
- MEM <= EX
- EX <= {ID_RF_ENABLE & (ID_DEST != 0), ID_LOAD_INSTR, ID_DEST}, or all-zero when IDEX_NOP=1.
REQ-006 OUT_Enable*/OUT_reg* SHALL present the valid/dest fields of the corresponding entry directly from flops (zero latency).
REQ-007 Load-use hazard (LU) SHALL assert combinationally when EX.valid & EX.load & ((ID_USES_RS & ID_RS==EX.dest) | (ID_USES_RT & ID_RT==EX.dest)).
REQ-008 While LU=1:
- PC_LE=0, IFID_LE=0, IDEX_NOP=1, IFID_FLUSH=0, FWD_A=FWD_B=00.
- ID_BRANCH_TAKEN SHALL be ignored (stall has priority).
REQ-009 While LU=0 and ID_BRANCH_TAKEN=1: PC_LE=1, IFID_LE=1, IFID_FLUSH=1, IDEX_NOP=0.
REQ-010 While LU=0 and ID_BRANCH_TAKEN=0: PC_LE=1, IFID_LE=1, IFID_FLUSH=0, IDEX_NOP=0.
REQ-011 Forward select for rs (and identically for rt with ID_RT/ID_USES_RT) SHALL use priority EX > MEM > WB:
- 01 if EX.valid & ~EX.load & EX.dest==ID_RS
- else 10 if MEM matches
- else 11 if WB matches
- else 00.
REQ-012 FWD SHALL be 00 whenever the source field is 0 or the corresponding USES input is 0.
REQ-013 A load in EX SHALL never yield FWD=01. After exactly one stall cycle the load sits in MEM and FWD SHALL be 10.
REQ-014 A control FSM SHALL have states RUN, STALL, FLUSH, registered each cycle:
- STALL when LU
- else FLUSH when ID_BRANCH_TAKEN
- else RUN.
The FSM state drives no outputs; it exists for debug and for STALL_CNT.
REQ-015 STALL_CNT SHALL increment by 1 on each posedge where LU=1, saturate at 16'hFFFF, and never wrap.
REQ-016 Back-to-back LU SHALL NOT occur for the same instruction: the bubble written in REQ-005 clears EX.valid, so LU deasserts in the cycle after a stall.

Reset
REQ-017 On a posedge with Reset=1:
- all scoreboard entries <= 0
- FSM <= RUN
- STALL_CNT <= 0
REQ-018 Reset SHALL override a stall or flush in progress; the cycle after Reset deasserts behaves as RUN with an empty scoreboard (PC_LE=1, FWD=00).
REQ-019 Reset asserted mid-operation SHALL discard all in-flight scoreboard entries. No forward SHALL reference a pre-reset instruction.

Verification
REQ-020 The bench SHALL cover:
- ALU-ALU: add $3 in ID, next cycle ID reads rs=3 -> FWD_A=01; one cycle later FWD_A=10; one more cycle FWD_A=11; then 00.
- Load-use: lw $5 in EX, ID uses rt=5 -> PC_LE=0, IFID_LE=0, IDEX_NOP=1, STALL_CNT 0->1; next cycle FWD_B=10, PC_LE=1.
- $0 target: ALU writing dest 0, next ID reads rs=0 -> OUT_EnableEX=0, FWD_A=00.
- Priority: $7 written in EX and in MEM, ID reads rs=7 -> FWD_A=01.
- Stall vs branch: LU=1 with ID_BRANCH_TAKEN=1 -> IFID_FLUSH=0, IDEX_NOP=1; next cycle with branch still 1 -> IFID_FLUSH=1.
- Reset during stall: Reset=1 while LU=1 -> next cycle all OUT_reg*=0, STALL_CNT=0, PC_LE=1.
